// File: rtl/nv_ram_rwsp_prm.sv
// nv_ram_rwsp_prm: parametrised single-clock RAM with one write port and one read port.
// The read address and the read data are both registered, giving a read latency of 2.
// Writes are byte-masked. An optional write-first bypass applies on a read/write collision.
// A read-valid tracker drives dout_vld, and an optional sweep clears the array after reset.
//
// Ports:
//   clk            sole clock, rising edge
//   reset_         asynchronous active-low reset
//   ra, re         read address; re captures ra into the read-address register
//   ore            output enable; loads dout from the registered read address
//   dout, dout_vld registered read data and its valid flag
//   wa, we, wmask, di  write address, enable, byte mask and data
//   init_busy      high while the post-reset clear sweep runs (re/we/ore ignored)
//   pwrbus_ram_pd  power-down bus, no functional effect
module nv_ram_rwsp_prm #(
    parameter int unsigned     WIDTH    = 16,
    parameter int unsigned     DEPTH    = 128,
    parameter int unsigned     AW       = 7,
    parameter int unsigned     MW       = WIDTH / 8,
    parameter bit              WR_FIRST = 1'b0,
    parameter bit              INIT_EN  = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    input  logic             ore,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [MW-1:0]    wmask,
    input  logic [WIDTH-1:0] di,
    output logic             init_busy,
    input  logic [31:0]      pwrbus_ram_pd
);

    localparam int unsigned BYTE_W = 8;
    // One extra bit so DEPTH == 2**AW compares correctly.
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IC = AW'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    ic_q, ic_d;
    logic [AW-1:0]    ra_q, ra_d;
    logic             rd_pend_q, rd_pend_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] wr_merged;
    logic             wa_ok;
    logic             ra_ok;
    logic             collide;

    logic             unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    // Byte-wise merge of new data into an existing word under a mask.
    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_w,
                                                     input logic [WIDTH-1:0] new_w,
                                                     input logic [MW-1:0]    mask);
        logic [WIDTH-1:0] res;
        res = old_w;
        for (int k = 0; k < int'(MW); k++) begin
            if (mask[k]) res[k*BYTE_W +: BYTE_W] = new_w[k*BYTE_W +: BYTE_W];
        end
        return res;
    endfunction

    assign wa_ok     = ({1'b0, wa}   < DEPTH_W);
    assign ra_ok     = ({1'b0, ra_q} < DEPTH_W);
    assign wr_merged = merge_bytes(mem[wa], di, wmask);
    assign collide   = we && wa_ok && (wa == ra_q);

    // State, counter and read-side registers.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= INIT_EN ? ST_INIT : ST_IDLE;
            ic_q       <= '0;
            ra_q       <= '0;
            rd_pend_q  <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ic_q       <= ic_d;
            ra_q       <= ra_d;
            rd_pend_q  <= rd_pend_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    // Next-state, array write port selection and read pipeline.
    always_comb begin
        state_d    = state_q;
        ic_d       = ic_q;
        ra_d       = ra_q;
        rd_pend_d  = rd_pend_q;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        mem_we     = 1'b0;
        mem_wa     = wa;
        mem_wdata  = wr_merged;

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_wa    = ic_q;
                mem_wdata = INIT_VAL;
                if (ic_q == LAST_IC) begin
                    state_d = ST_IDLE;
                end else begin
                    ic_d = ic_q + AW'(1);
                end
            end
            ST_IDLE: begin
                mem_we = we && wa_ok && (|wmask);
                if (ore) begin
                    if (!ra_ok) begin
                        dout_d = '0;
                    end else if (WR_FIRST && collide) begin
                        dout_d = wr_merged;
                    end else begin
                        dout_d = mem[ra_q];
                    end
                    dout_vld_d = rd_pend_q;
                    rd_pend_d  = 1'b0;
                end
                if (re) begin
                    ra_d      = ra;
                    rd_pend_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Storage array; not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wdata;
    end

    assign dout      = dout_q;
    assign dout_vld  = dout_vld_q;
    assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_nv_ram_rwsp_prm.sv
// Testbench for nv_ram_rwsp_prm. Two instances share the same stimulus:
//   A: defaults (DEPTH=128, WR_FIRST=0); B: DEPTH=100, WR_FIRST=1.
// A behavioural model of each is compared every cycle, plus literal spot checks.
module tb_nv_ram_rwsp_prm;

    localparam int DEP_A = 128;
    localparam int DEP_B = 100;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic [6:0]  ra = '0;
    logic        re = 1'b0;
    logic        ore = 1'b0;
    logic [6:0]  wa = '0;
    logic        we = 1'b0;
    logic [1:0]  wmask = '0;
    logic [15:0] di = '0;
    logic [31:0] pwrbus_ram_pd = '0;

    logic [15:0] dout_a, dout_b;
    logic        vld_a, vld_b, busy_a, busy_b;

    int n_cmp = 0;
    int n_err = 0;
    bit run   = 1'b0;

    always #5 clk = ~clk;

    nv_ram_rwsp_prm u_a (
        .clk(clk), .reset_(reset_), .ra(ra), .re(re), .ore(ore),
        .dout(dout_a), .dout_vld(vld_a), .wa(wa), .we(we), .wmask(wmask),
        .di(di), .init_busy(busy_a), .pwrbus_ram_pd(pwrbus_ram_pd)
    );

    nv_ram_rwsp_prm #(.DEPTH(100), .WR_FIRST(1'b1)) u_b (
        .clk(clk), .reset_(reset_), .ra(ra), .re(re), .ore(ore),
        .dout(dout_b), .dout_vld(vld_b), .wa(wa), .we(we), .wmask(wmask),
        .di(di), .init_busy(busy_b), .pwrbus_ram_pd(pwrbus_ram_pd)
    );

    // ---------------- behavioural model ----------------
    logic [15:0] mm    [2][128];
    int          left  [2];
    logic        pend  [2];
    logic [6:0]  addr  [2];
    logic [15:0] edout [2];
    logic        evld  [2];

    function automatic int dep_of(input int i);
        return (i == 0) ? DEP_A : DEP_B;
    endfunction

    function automatic bit wrf_of(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [15:0] mrg(input logic [15:0] o, input logic [15:0] n,
                                        input logic [1:0] m);
        return {m[1] ? n[15:8] : o[15:8], m[0] ? n[7:0] : o[7:0]};
    endfunction

    always @(posedge clk or negedge reset_) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_) begin
                left[i]  <= dep_of(i);
                pend[i]  <= 1'b0;
                addr[i]  <= '0;
                edout[i] <= '0;
                evld[i]  <= 1'b0;
            end else if (left[i] != 0) begin
                // Array is unobservable during the sweep, so clear it when the sweep ends.
                left[i] <= left[i] - 1;
                if (left[i] == 1) begin
                    for (int j = 0; j < 128; j++) mm[i][j] <= 16'h0000;
                end
            end else begin
                if (ore) begin
                    evld[i] <= pend[i];
                    if (int'(addr[i]) >= dep_of(i))
                        edout[i] <= 16'h0000;
                    else if (wrf_of(i) && we && wa == addr[i])
                        edout[i] <= mrg(mm[i][addr[i]], di, wmask);
                    else
                        edout[i] <= mm[i][addr[i]];
                end
                if (re) begin
                    addr[i] <= ra;
                    pend[i] <= 1'b1;
                end else if (ore) begin
                    pend[i] <= 1'b0;
                end
                if (we && int'(wa) < dep_of(i)) mm[i][wa] <= mrg(mm[i][wa], di, wmask);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (run) begin
            chk("dout_a", dout_a, edout[0]);
            chk("vld_a",  16'(vld_a),  16'(evld[0]));
            chk("busy_a", 16'(busy_a), 16'(left[0] != 0));
            chk("dout_b", dout_b, edout[1]);
            chk("vld_b",  16'(vld_b),  16'(evld[1]));
            chk("busy_b", 16'(busy_b), 16'(left[1] != 0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic re_v, input logic [6:0] ra_v, input logic ore_v,
                         input logic we_v, input logic [6:0] wa_v, input logic [1:0] wm_v,
                         input logic [15:0] di_v);
        @(negedge clk);
        re = re_v; ra = ra_v; ore = ore_v;
        we = we_v; wa = wa_v; wmask = wm_v; di = di_v;
    endtask

    task automatic idle();
        drive(1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 2'b00, 16'h0);
    endtask

    task automatic wr(input logic [6:0] a, input logic [15:0] d, input logic [1:0] m);
        drive(1'b0, 7'd0, 1'b0, 1'b1, a, m, d);
    endtask

    // Read: re, then ore, then one idle so the result is visible on return.
    task automatic rd(input logic [6:0] a);
        drive(1'b1, a, 1'b0, 1'b0, 7'd0, 2'b00, 16'h0);
        drive(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 2'b00, 16'h0);
        idle();
    endtask

    task automatic rand_in();
        drive(1'($urandom), 7'($urandom), 1'($urandom), 1'($urandom), 7'($urandom),
              2'($urandom), 16'($urandom));
    endtask

    // Release reset and count init_busy cycles; inputs random only while both are busy.
    task automatic release_and_count(input string tag);
        int ca = 0;
        int cb = 0;
        @(negedge clk);
        reset_ = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (busy_a) ca++;
            if (busy_b) cb++;
            if (busy_a && busy_b) rand_in();
            else idle();
        end
        chk({tag, "_busy_len_a"}, 16'(ca), 16'(DEP_A));
        chk({tag, "_busy_len_b"}, 16'(cb), 16'(DEP_B));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dout_a", dout_a, 16'h0);
        chk("rst_vld_a",  16'(vld_a), 16'h0);
        chk("rst_busy_a", 16'(busy_a), 16'h1);
        chk("rst_busy_b", 16'(busy_b), 16'h1);
        run = 1'b1;
        release_and_count("first");

        // Init sweep clears prior contents.
        for (int a = 0; a < 128; a++) wr(7'(a), 16'hFFFF, 2'b11);
        idle();
        @(negedge clk); #2; reset_ = 1'b0;
        release_and_count("sweep");
        for (int a = 0; a < 128; a++) begin
            rd(7'(a));
            chk("sweep_dout_a", dout_a, 16'h0000);
            chk("sweep_vld_a",  16'(vld_a), 16'h1);
        end

        // Latency and hold.
        wr(7'd5, 16'h1234, 2'b11);
        drive(1'b1, 7'd5, 1'b0, 1'b0, 7'd0, 2'b00, 16'h0);
        idle(); idle();
        chk("lat_early_vld", 16'(vld_a), 16'h1);
        drive(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 2'b00, 16'h0);
        idle();
        chk("lat_dout", dout_a, 16'h1234);
        chk("lat_vld",  16'(vld_a), 16'h1);
        drive(1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 2'b00, 16'h0);
        idle();
        chk("lat_consumed_vld", 16'(vld_a), 16'h0);
        chk("lat_consumed_dout", dout_a, 16'h1234);

        // Byte mask.
        wr(7'd9, 16'hAABB, 2'b11);
        wr(7'd9, 16'h11CC, 2'b01);
        wr(7'd9, 16'h9999, 2'b00);
        rd(7'd9);
        chk("mask_a", dout_a, 16'hAACC);
        chk("mask_b", dout_b, 16'hAACC);

        // Collision.
        wr(7'd3, 16'h0F0F, 2'b11);
        drive(1'b1, 7'd3, 1'b0, 1'b0, 7'd0, 2'b00, 16'h0);
        drive(1'b0, 7'd0, 1'b1, 1'b1, 7'd3, 2'b10, 16'h7777);
        idle();
        chk("coll_old_a", dout_a, 16'h0F0F);
        chk("coll_fwd_b", dout_b, 16'h770F);
        rd(7'd3);
        chk("coll_after_a", dout_a, 16'h770F);
        chk("coll_after_b", dout_b, 16'h770F);

        // Out-of-range write/read on the 100-deep instance.
        wr(7'd110, 16'h5555, 2'b11);
        rd(7'd110);
        chk("oor_a", dout_a, 16'h5555);
        chk("oor_b", dout_b, 16'h0000);
        chk("oor_vld_b", 16'(vld_b), 16'h1);

        // Asynchronous reset clears dout immediately.
        #2; reset_ = 1'b0; #1;
        chk("async_dout_a", dout_a, 16'h0);
        chk("async_busy_a", 16'(busy_a), 16'h1);
        chk("async_busy_b", 16'(busy_b), 16'h1);
        @(negedge clk);
        reset_ = 1'b1;
        for (int c = 0; c < 40; c++) rand_in();
        #2; reset_ = 1'b0; #1;
        chk("midinit_busy_a", 16'(busy_a), 16'h1);
        chk("midinit_dout_a", dout_a, 16'h0);
        release_and_count("restart");
        rd(7'd7);
        chk("init_ignored_a", dout_a, 16'h0000);
        chk("init_ignored_b", dout_b, 16'h0000);

        // Randomised traffic, narrow address range to provoke collisions.
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7)),
                  2'($urandom), 16'($urandom));
        end
        idle(); idle();
        run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
